// File: rtl/bcd_pkg.sv
// Shared BCD constants and helpers: nibble validity check and digit-wise magnitude compare.
package bcd_pkg;

  localparam int unsigned BCD_W          = 4;
  localparam logic [3:0]  BCD_MAX        = 4'd9;
  localparam int unsigned BCD_MAX_DIGITS = 8;
  localparam int unsigned BCD_WORD_W     = BCD_W * BCD_MAX_DIGITS;

  // True when every nibble of the (zero-extended) word is a decimal digit.
  function automatic logic bcd_valid(input logic [BCD_WORD_W-1:0] value);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < BCD_MAX_DIGITS; i++) begin
      if (value[i*BCD_W +: BCD_W] > BCD_MAX) begin
        ok = 1'b0;
      end else begin
        ok = ok;
      end
    end
    return ok;
  endfunction

  // a <= b, comparing digits from the most significant downwards.
  function automatic logic bcd_le(input logic [BCD_WORD_W-1:0] a,
                                  input logic [BCD_WORD_W-1:0] b);
    for (int i = BCD_MAX_DIGITS - 1; i >= 0; i--) begin
      if (a[i*BCD_W +: BCD_W] != b[i*BCD_W +: BCD_W]) begin
        return (a[i*BCD_W +: BCD_W] < b[i*BCD_W +: BCD_W]);
      end else begin
        continue;
      end
    end
    return 1'b1;
  endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD digit of the chain: steps up or down when step_in is set and
// forwards a carry (9->0) or borrow (0->9) to the next digit.
module bcd_digit_cell
  import bcd_pkg::*;
(
  input  logic [BCD_W-1:0] digit,
  input  logic             step_in,
  input  logic             down,
  output logic [BCD_W-1:0] next_digit,
  output logic             step_out
);

  // Combinational single-digit increment/decrement with wrap.
  always_comb begin
    next_digit = digit;
    step_out   = 1'b0;
    if (step_in) begin
      if (down) begin
        if (digit == 4'd0) begin
          next_digit = BCD_MAX;
          step_out   = 1'b1;
        end else begin
          next_digit = digit - 4'd1;
        end
      end else begin
        if (digit == BCD_MAX) begin
          next_digit = 4'd0;
          step_out   = 1'b1;
        end else begin
          next_digit = digit + 4'd1;
        end
      end
    end else begin
      next_digit = digit;
    end
  end

endmodule

// File: rtl/bcd_chain_counter.sv
// Cascaded BCD up/down counter bounded by LIMIT, with validated parallel load,
// wrap or saturate behaviour at the bounds and registered status flags.
module bcd_chain_counter
  import bcd_pkg::*;
#(
  parameter int unsigned         DIGITS   = 2,
  parameter logic [4*DIGITS-1:0] LIMIT    = 8'h59,
  parameter bit                  SATURATE = 1'b0
) (
  input  logic                clock,
  input  logic                clear,
  input  logic                enable_Count,
  input  logic                count_Down,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_Value,
  output logic [4*DIGITS-1:0] counter,
  output logic                carry_Over,
  output logic                borrow_Out,
  output logic                at_Limit,
  output logic                is_Zero,
  output logic                load_Error
);

  localparam int unsigned   CW   = BCD_W * DIGITS;
  localparam logic [CW-1:0] ZERO = {CW{1'b0}};

  logic [CW-1:0]   count_r    = {CW{1'b0}};
  logic            carry_r    = 1'b0;
  logic            borrow_r   = 1'b0;
  logic            lerr_r     = 1'b0;
  logic            at_limit_r = (LIMIT == {CW{1'b0}});
  logic            zero_r     = 1'b1;

  logic [DIGITS:0] ripple_s;
  logic [CW-1:0]   stepped_s;
  logic            load_ok_s;
  logic            under_s;
  logic [CW-1:0]   next_count_s;
  logic            next_carry_s;
  logic            next_borrow_s;
  logic            next_lerr_s;

  assign ripple_s[0] = 1'b1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit_cell u_cell (
      .digit      (count_r[g*BCD_W +: BCD_W]),
      .step_in    (ripple_s[g]),
      .down       (count_Down),
      .next_digit (stepped_s[g*BCD_W +: BCD_W]),
      .step_out   (ripple_s[g+1])
    );
  end

  // A borrow falling off the top digit means the whole count was zero.
  assign under_s   = count_Down & ripple_s[DIGITS];
  assign load_ok_s = bcd_valid(BCD_WORD_W'(load_Value)) &&
                     bcd_le(BCD_WORD_W'(load_Value), BCD_WORD_W'(LIMIT));

  // Next-state selection: load beats counting; bounds wrap or hold.
  always_comb begin
    next_count_s  = count_r;
    next_carry_s  = 1'b0;
    next_borrow_s = 1'b0;
    next_lerr_s   = 1'b0;
    if (load) begin
      if (load_ok_s) begin
        next_count_s = load_Value;
      end else begin
        next_lerr_s = 1'b1;
      end
    end else if (enable_Count) begin
      if (!count_Down) begin
        if (count_r == LIMIT) begin
          if (SATURATE) begin
            next_count_s = count_r;
          end else begin
            next_count_s = ZERO;
            next_carry_s = 1'b1;
          end
        end else begin
          next_count_s = stepped_s;
        end
      end else begin
        if (under_s) begin
          if (SATURATE) begin
            next_count_s = count_r;
          end else begin
            next_count_s  = LIMIT;
            next_borrow_s = 1'b1;
          end
        end else begin
          next_count_s = stepped_s;
        end
      end
    end else begin
      next_count_s = count_r;
    end
  end

  // State and flag registers; flags derive from next state so they align with counter.
  always_ff @(posedge clock) begin
    if (clear) begin
      count_r    <= ZERO;
      carry_r    <= 1'b0;
      borrow_r   <= 1'b0;
      lerr_r     <= 1'b0;
      at_limit_r <= (LIMIT == ZERO);
      zero_r     <= 1'b1;
    end else begin
      count_r    <= next_count_s;
      carry_r    <= next_carry_s;
      borrow_r   <= next_borrow_s;
      lerr_r     <= next_lerr_s;
      at_limit_r <= (next_count_s == LIMIT);
      zero_r     <= (next_count_s == ZERO);
    end
  end

  assign counter    = count_r;
  assign carry_Over = carry_r;
  assign borrow_Out = borrow_r;
  assign load_Error = lerr_r;
  assign at_Limit   = at_limit_r;
  assign is_Zero    = zero_r;

endmodule
